// File: rtl/ndata_packer.sv
// Repacks prefix-compacted beats into dense NUM_ELEMENTS-wide beats, carrying residual
// elements across beats and flushing the remainder on each packet's last beat.
//
// state | meaning
// ACCUM | accepting input; residual buffer holds cnt_q elements of the current packet
// FLUSH | last input beat overflowed one output beat; emit residual as the last beat
module ndata_packer #(
    parameter type data_t       = logic [7:0],
    parameter int  NUM_ELEMENTS = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  data_t [NUM_ELEMENTS-1:0] in_data,
    input  logic  [NUM_ELEMENTS-1:0] in_keep,
    input  logic                     in_last,
    input  logic                     in_valid,
    output logic                     in_ready,
    output data_t [NUM_ELEMENTS-1:0] out_data,
    output logic  [NUM_ELEMENTS-1:0] out_keep,
    output logic                     out_last,
    output logic                     out_valid,
    input  logic                     out_ready
);
    localparam int N  = NUM_ELEMENTS;
    localparam int CW = $clog2(N);
    localparam int TW = CW + 1;

    typedef enum logic {ACCUM, FLUSH} state_t;

    state_t                state_q, state_d;
    data_t                 res_q [N-1];
    data_t                 res_d [N-1];
    logic  [CW-1:0]        cnt_q, cnt_d;
    data_t                 cat [2*N-1];
    data_t [N-1:0]         out_data_d;
    logic  [N-1:0]         out_keep_d, t_keep, cnt_keep;
    logic                  out_last_d, out_valid_d;
    logic  [TW-1:0]        n_in, t_sum;
    logic                  slot_free, accept, t_ge_n, t_gt_n;

    assign slot_free = !out_valid || out_ready;
    assign in_ready  = (state_q == ACCUM) && slot_free;
    assign accept    = in_valid && in_ready;

    always_comb begin
        n_in = '0;
        for (int i = 0; i < N; i++) n_in = n_in + TW'(in_keep[i]);
    end

    assign t_sum  = TW'(cnt_q) + n_in;
    assign t_ge_n = t_sum >= TW'(N);
    assign t_gt_n = t_sum > TW'(N);

    // Residual first, then input lanes shifted up by cnt_q.
    always_comb begin
        for (int i = 0; i < 2*N-1; i++) begin
            cat[i] = '0;
            for (int j = 0; j < N; j++) begin
                if (TW'(j) + TW'(cnt_q) == TW'(i)) cat[i] = in_data[j];
            end
        end
        for (int i = 0; i < N-1; i++) begin
            if (CW'(i) < cnt_q) cat[i] = res_q[i];
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            t_keep[i]   = TW'(i) < t_sum;
            cnt_keep[i] = CW'(i) < cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= ACCUM;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (state_q == ACCUM) begin
            if (accept && in_last && t_gt_n) state_d = FLUSH;
        end else begin
            if (slot_free) state_d = ACCUM;
        end
    end

    always_comb begin
        out_data_d  = out_data;
        out_keep_d  = out_keep;
        out_last_d  = out_last;
        out_valid_d = out_valid;
        res_d       = res_q;
        cnt_d       = cnt_q;
        if (out_valid && out_ready) out_valid_d = 1'b0;
        if (state_q == FLUSH) begin
            if (slot_free) begin
                out_data_d = '0;
                for (int i = 0; i < N-1; i++) out_data_d[i] = res_q[i];
                out_keep_d  = cnt_keep;
                out_last_d  = 1'b1;
                out_valid_d = 1'b1;
                cnt_d       = '0;
            end
        end else if (accept) begin
            if (!in_last && !t_ge_n) begin
                for (int k = 0; k < N-1; k++) res_d[k] = cat[k];
                cnt_d = CW'(t_sum);
            end else if (!in_last || t_gt_n) begin
                for (int i = 0; i < N; i++) out_data_d[i] = cat[i];
                for (int k = 0; k < N-1; k++) res_d[k] = cat[N+k];
                out_keep_d  = '1;
                out_last_d  = 1'b0;
                out_valid_d = 1'b1;
                cnt_d       = CW'(t_sum - TW'(N));
            end else begin
                for (int i = 0; i < N; i++) out_data_d[i] = cat[i];
                out_keep_d  = t_keep;
                out_last_d  = 1'b1;
                out_valid_d = 1'b1;
                cnt_d       = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data  <= '0;
            out_keep  <= '0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
            cnt_q     <= '0;
            for (int k = 0; k < N-1; k++) res_q[k] <= '0;
        end else begin
            out_data  <= out_data_d;
            out_keep  <= out_keep_d;
            out_last  <= out_last_d;
            out_valid <= out_valid_d;
            cnt_q     <= cnt_d;
            res_q     <= res_d;
        end
    end

    // Upstream compactor guarantees keep is a contiguous prefix.
    keep_is_prefix: assert property (@(posedge clk) disable iff (rst)
        in_valid |-> ((in_keep & (in_keep + N'(1))) == '0));

endmodule

// File: tb/tb_ndata_packer.sv
// Directed bench for ndata_packer at N=4: expected beats are queued as stimulus is driven
// and popped whenever the packer hands a beat downstream.
module tb_ndata_packer;
    localparam int N = 4;
    typedef logic [7:0] elem_t;

    logic              clk = 1'b0;
    logic              rst;
    elem_t [N-1:0]     in_data, out_data;
    logic  [N-1:0]     in_keep, out_keep;
    logic              in_last, in_valid, in_ready;
    logic              out_last, out_valid, out_ready;

    ndata_packer #(.data_t(elem_t), .NUM_ELEMENTS(N)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_keep(in_keep), .in_last(in_last),
        .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_keep(out_keep), .out_last(out_last),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } beat_t;

    beat_t exp_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    int    cyc = 0;
    int    last_acc_cyc = 0;
    int    prev_out_cyc = -10;
    int    run_len = 0;
    int    run_start = 0;

    function automatic logic [31:0] pk(input logic [7:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    function automatic logic [31:0] masked(input logic [31:0] d, input logic [3:0] k);
        logic [31:0] r;
        r = d;
        for (int i = 0; i < N; i++) if (!k[i]) r[8*i +: 8] = 8'h00;
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic expect_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
        beat_t b;
        b.data = d; b.keep = k; b.last = l;
        exp_q.push_back(b);
    endtask

    task automatic tick(output bit acc);
        beat_t e;
        @(negedge clk);
        acc = in_valid && in_ready;
        if (out_valid && out_ready) begin
            if (cyc == prev_out_cyc + 1) run_len++;
            else begin
                run_len   = 1;
                run_start = cyc;
            end
            prev_out_cyc = cyc;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $error("FAIL unexpected_beat observed data=%h keep=%b expected none", out_data, out_keep);
            end else begin
                e = exp_q.pop_front();
                check("out_keep", 32'(out_keep), 32'(e.keep));
                check("out_last", 32'(out_last), 32'(e.last));
                check("out_data", masked(out_data, e.keep), masked(e.data, e.keep));
            end
        end
        @(posedge clk);
        if (acc) last_acc_cyc = cyc;
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) tick(acc);
    endtask

    task automatic drive(input logic [31:0] d, input logic [3:0] k, input logic l);
        bit acc;
        in_data  = d;
        in_keep  = k;
        in_last  = l;
        in_valid = 1'b1;
        acc      = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) tick(acc);
        if (!acc) begin
            n_cmp++;
            n_bad++;
            $error("FAIL drive_timeout observed=no_accept expected=accept");
        end
        in_valid = 1'b0;
    endtask

    initial begin
        bit acc;
        int a0;
        rst       = 1'b1;
        in_data   = '0;
        in_keep   = '0;
        in_last   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        idle(2);
        rst = 1'b0;

        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_keep", 32'(out_keep), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Residual carried across beats, packet closed by a short last beat.
        expect_beat(pk(8'hA0, 8'hA1, 8'hB0, 8'hB1), 4'b1111, 1'b0);
        expect_beat(pk(8'hB2, 8'hC0, 8'h00, 8'h00), 4'b0011, 1'b1);
        drive(pk(8'hA0, 8'hA1, 8'hEE, 8'hEE), 4'b0011, 1'b0);
        drive(pk(8'hB0, 8'hB1, 8'hB2, 8'hEE), 4'b0111, 1'b0);
        drive(pk(8'hC0, 8'hEE, 8'hEE, 8'hEE), 4'b0001, 1'b1);
        idle(2);

        // Last beat overflows: one extra FLUSH cycle with input stalled.
        expect_beat(pk(8'h10, 8'h11, 8'h12, 8'h20), 4'b1111, 1'b0);
        expect_beat(pk(8'h21, 8'h22, 8'h23, 8'h00), 4'b0111, 1'b1);
        drive(pk(8'h10, 8'h11, 8'h12, 8'hEE), 4'b0111, 1'b0);
        drive(pk(8'h20, 8'h21, 8'h22, 8'h23), 4'b1111, 1'b1);
        check("flush_in_ready_low", 32'(in_ready), 32'd0);
        tick(acc);
        check("post_flush_in_ready", 32'(in_ready), 32'd1);
        idle(2);

        // Downstream stall for 5 cycles.
        out_ready = 1'b0;
        expect_beat(pk(8'h30, 8'h31, 8'h32, 8'h33), 4'b1111, 1'b0);
        expect_beat(pk(8'h38, 8'h39, 8'h00, 8'h00), 4'b0011, 1'b1);
        drive(pk(8'h30, 8'h31, 8'h32, 8'h33), 4'b1111, 1'b0);
        in_data  = pk(8'h38, 8'h39, 8'hEE, 8'hEE);
        in_keep  = 4'b0011;
        in_last  = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("stall_out_valid", 32'(out_valid), 32'd1);
            check("stall_out_data", out_data, pk(8'h30, 8'h31, 8'h32, 8'h33));
            check("stall_out_keep", 32'(out_keep), 32'hF);
            check("stall_out_last", 32'(out_last), 32'd0);
            check("stall_in_ready", 32'(in_ready), 32'd0);
            tick(acc);
            check("stall_no_accept", 32'(acc), 32'd0);
        end
        out_ready = 1'b1;
        drive(pk(8'h38, 8'h39, 8'hEE, 8'hEE), 4'b0011, 1'b1);
        idle(2);

        // Empty packet with nothing buffered.
        expect_beat(32'h0, 4'b0000, 1'b1);
        drive(pk(8'hEE, 8'hEE, 8'hEE, 8'hEE), 4'b0000, 1'b1);
        idle(3);

        // 16 back-to-back full beats: pass-through at one beat per cycle.
        a0 = 0;
        for (int b = 0; b < 16; b++) begin
            logic [31:0] d;
            d = pk(8'(8'h40 + 4*b), 8'(8'h41 + 4*b), 8'(8'h42 + 4*b), 8'(8'h43 + 4*b));
            expect_beat(d, 4'b1111, 1'b0);
            drive(d, 4'b1111, 1'b0);
            if (b == 0) a0 = last_acc_cyc;
        end
        idle(2);
        check("b2b_run_length", 32'(run_len), 32'd16);
        check("b2b_latency", 32'(run_start - a0), 32'd1);

        // Reset mid-packet drops the residual.
        drive(pk(8'hD0, 8'hD1, 8'hEE, 8'hEE), 4'b0011, 1'b0);
        rst = 1'b1;
        tick(acc);
        rst = 1'b0;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        expect_beat(pk(8'hE0, 8'hE1, 8'hE2, 8'hE3), 4'b1111, 1'b1);
        drive(pk(8'hE0, 8'hE1, 8'hE2, 8'hE3), 4'b1111, 1'b1);
        idle(3);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
